// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the Division/Root operation scheduler.
package arith_sched_pkg;

  localparam logic MODE_DIV  = 1'b0;
  localparam logic MODE_ROOT = 1'b1;

  localparam int unsigned Data1W  = 10;
  localparam int unsigned Data2W  = 3;
  localparam int unsigned ResultW = 20;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } sched_state_e;

  typedef struct packed {
    logic              mode;
    logic [Data1W-1:0] data_1;
    logic [Data2W-1:0] data_2;
  } sched_req_t;

endpackage

// File: rtl/sched_req_fifo.sv
// Request FIFO for the scheduler: registered count, power-of-two depth, pointers wrap naturally.
module sched_req_fifo
  import arith_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  sched_req_t      wdata_i,
  input  logic            pop_i,
  output sched_req_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  sched_req_t mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign push = push_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Issues queued Division/Root requests one at a time, waits for the unit's done pulse under a
// timeout watchdog, and returns each result in order on a valid/ready port.
module arith_op_scheduler
  import arith_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [Data1W-1:0]  req_data_1,
  input  logic [Data2W-1:0]  req_data_2,
  output logic               div_start,
  output logic               root_start,
  output logic [Data1W-1:0]  unit_data_1,
  output logic [Data2W-1:0]  unit_data_2,
  input  logic               div_done,
  input  logic [ResultW-1:0] div_result,
  input  logic               root_done,
  input  logic [ResultW-1:0] root_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ResultW-1:0] out_data,
  output logic               out_mode,
  output logic               out_err,
  output logic               busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  sched_state_e       state_q, state_d;
  sched_req_t         op_q, op_d;
  logic [TimerW-1:0]  timer_q, timer_d, timer_inc;
  logic               out_valid_q, out_valid_d;
  logic [ResultW-1:0] out_data_q, out_data_d;
  logic               out_mode_q, out_mode_d;
  logic               out_err_q, out_err_d;

  sched_req_t         fifo_wdata, fifo_rdata;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]    fifo_count;
  logic               sel_done;
  logic [ResultW-1:0] sel_result;

  assign fifo_wdata = '{mode: req_mode, data_1: req_data_1, data_2: req_data_2};

  sched_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (req_valid && req_ready),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Only the unit that was started may complete the op.
  assign sel_done   = (op_q.mode == MODE_ROOT) ? root_done : div_done;
  assign sel_result = (op_q.mode == MODE_ROOT) ? root_result : div_result;
  assign timer_inc  = timer_q + TimerW'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    timer_d     = timer_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    fifo_pop    = 1'b0;
    div_start   = 1'b0;
    root_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_rdata;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        div_start  = (op_q.mode == MODE_DIV);
        root_start = (op_q.mode == MODE_ROOT);
        timer_d    = '0;
        state_d    = StWait;
      end
      StWait: begin
        // Timer holds cycles elapsed since the start pulse; done wins over a coincident timeout.
        timer_d = timer_inc;
        if (sel_done) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_mode_d  = op_q.mode;
          out_data_d  = sel_result;
          state_d     = StHold;
        end else if (timer_inc == TimerW'(TIMEOUT - 1)) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_mode_d  = op_q.mode;
          out_data_d  = '0;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
    end
  end

  assign req_ready   = !fifo_full;
  assign unit_data_1 = op_q.data_1;
  assign unit_data_2 = op_q.data_2;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_mode    = out_mode_q;
  assign out_err     = out_err_q;
  assign busy        = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_arith_op_scheduler.sv
// Directed bench for arith_op_scheduler: vector table for single ops plus hand-written sequences
// for backpressure, ordering/stall and reset mid-operation.
module tb_arith_op_scheduler;
  import arith_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_mode = 1'b0;
  logic [9:0]  req_data_1 = '0;
  logic [2:0]  req_data_2 = '0;
  logic        div_done = 1'b0, root_done = 1'b0, out_ready = 1'b0;
  logic [19:0] div_result = '0, root_result = '0;
  logic        req_ready, div_start, root_start, out_valid, out_mode, out_err, busy;
  logic [9:0]  unit_data_1;
  logic [2:0]  unit_data_2;
  logic [19:0] out_data;

  int unsigned cyc = 0;
  int          div_starts = 0, root_starts = 0, both_starts = 0;
  int          n_total = 0, n_pass = 0;

  arith_op_scheduler #(
    .DEPTH  (4),
    .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_data_1 (req_data_1),
    .req_data_2 (req_data_2),
    .div_start  (div_start),
    .root_start (root_start),
    .unit_data_1(unit_data_1),
    .unit_data_2(unit_data_2),
    .div_done   (div_done),
    .div_result (div_result),
    .root_done  (root_done),
    .root_result(root_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) div_starts <= div_starts + 1;
    if (root_start) root_starts <= root_starts + 1;
    if (div_start && root_start) both_starts <= both_starts + 1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  typedef struct {
    logic        mode;
    logic [9:0]  d1;
    logic [2:0]  d2;
    int          lat;       // cycles from start pulse to done; negative = unit stays silent
    logic [19:0] res;
    logic [19:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string p);
    chk({p, "_div_start"}, div_start, 0);
    chk({p, "_root_start"}, root_start, 0);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_out_data"}, out_data, 0);
    chk({p, "_out_mode"}, out_mode, 0);
    chk({p, "_out_err"}, out_err, 0);
    chk({p, "_unit_d1"}, unit_data_1, 0);
    chk({p, "_unit_d2"}, unit_data_2, 0);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_busy"}, busy, 0);
  endtask

  // Entered at posedge+1; returns at the negedge of the cycle the start pulse is seen.
  task automatic wait_start(input logic m, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(div_start || root_start) && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    chk({nm, "_start_seen"}, div_start || root_start, 1);
    chk({nm, "_div_start"}, div_start, m == MODE_DIV);
    chk({nm, "_root_start"}, root_start, m == MODE_ROOT);
  endtask

  // Entered at posedge+1 with out_valid high; returns at posedge+1 two cycles after the handshake
  // cycle h, which is the earliest cycle a new start may appear.
  task automatic handshake(output int unsigned h);
    out_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    chk("hs_valid", out_valid, 1);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("hs_cleared", out_valid, 0);
    step();
  endtask

  task automatic drive_done(input logic m, input logic [19:0] r);
    div_done    = (m == MODE_DIV);
    root_done   = (m == MODE_ROOT);
    div_result  = r;
    root_result = r;
  endtask

  task automatic clear_done();
    div_done  = 1'b0;
    root_done = 1'b0;
  endtask

  initial begin
    int unsigned c0, h;
    int          n_wait, d0, r0, st, accepted;

    vecs[0] = '{MODE_DIV,  10'd1000, 3'd7, 5,  20'h00123, 20'h00123, 1'b0};
    vecs[1] = '{MODE_ROOT, 10'd81,   3'd2, 3,  20'h00009, 20'h00009, 1'b0};
    vecs[2] = '{MODE_DIV,  10'd50,   3'd5, 1,  20'h0000A, 20'h0000A, 1'b0};
    vecs[3] = '{MODE_ROOT, 10'd144,  3'd0, -1, 20'h0000C, 20'h00000, 1'b1};
    vecs[4] = '{MODE_DIV,  10'd1023, 3'd7, 63, 20'hFFFFF, 20'hFFFFF, 1'b0};

    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ops: start latency, done->valid latency, timeout, done/timeout coincidence.
    for (int i = 0; i < 5; i++) begin
      d0 = div_starts;
      r0 = root_starts;
      c0 = cyc;
      req_valid  = 1'b1;
      req_mode   = vecs[i].mode;
      req_data_1 = vecs[i].d1;
      req_data_2 = vecs[i].d2;
      step();
      req_valid = 1'b0;
      wait_start(vecs[i].mode, "vec");
      chk("vec_start_cycle", cyc - c0, 2);
      chk("vec_unit_d1", unit_data_1, vecs[i].d1);
      chk("vec_unit_d2", unit_data_2, vecs[i].d2);
      n_wait = (vecs[i].lat >= 0) ? vecs[i].lat : 63;
      repeat (n_wait) step();
      if (vecs[i].lat >= 0) drive_done(vecs[i].mode, vecs[i].res);
      @(negedge clk);
      chk("vec_valid_early", out_valid, 0);
      step();
      clear_done();
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[i].exp_data);
      chk("vec_mode", out_mode, vecs[i].mode);
      chk("vec_err", out_err, vecs[i].exp_err);
      chk("vec_div_pulses", div_starts - d0, vecs[i].mode == MODE_DIV);
      chk("vec_root_pulses", root_starts - r0, vecs[i].mode == MODE_ROOT);
      // A late done while holding the result must be dropped.
      step();
      drive_done(vecs[i].mode, 20'h5A5A5);
      step();
      clear_done();
      @(negedge clk);
      chk("late_done_data", out_data, vecs[i].exp_data);
      chk("late_done_err", out_err, vecs[i].exp_err);
      step();
      handshake(h);
    end

    // Fill and backpressure: silent unit, 7 attempted pushes, 5 should land (one is popped).
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid  = 1'b1;
      req_mode   = MODE_DIV;
      req_data_1 = 10'(20 + i);
      req_data_2 = 3'(i);
      @(negedge clk);
      if (req_ready) accepted++;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", accepted, 5);
    chk("fill_ready_low", req_ready, 0);
    chk("fill_busy", busy, 1);
    chk("fill_hold_d1", unit_data_1, 20);
    step();
    drive_done(MODE_DIV, 20'd20);
    step();
    clear_done();
    @(negedge clk);
    chk("drain0_data", out_data, 20);
    step();
    handshake(h);
    for (int j = 1; j < 5; j++) begin
      wait_start(MODE_DIV, "drain");
      chk("drain_gap", cyc - h, 2);
      chk("drain_d1", unit_data_1, 20 + j);
      chk("drain_d2", unit_data_2, j);
      step();
      drive_done(MODE_DIV, 20'(20 + j));
      step();
      clear_done();
      @(negedge clk);
      chk("drain_data", out_data, 20 + j);
      step();
      handshake(h);
    end
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_ready", req_ready, 1);
    step();

    // Ordering, wrong-unit done, output stall.
    c0 = cyc;
    req_valid = 1'b1;
    req_mode = MODE_DIV;  req_data_1 = 10'd100; req_data_2 = 3'd3; step();
    req_mode = MODE_ROOT; req_data_1 = 10'd81;  req_data_2 = 3'd2; step();
    req_mode = MODE_DIV;  req_data_1 = 10'd50;  req_data_2 = 3'd5;
    @(negedge clk);
    chk("ord0_div_start", div_start, 1);
    chk("ord0_cycle", cyc - c0, 2);
    chk("ord0_d1", unit_data_1, 100);
    chk("ord0_d2", unit_data_2, 3);
    step();
    req_valid   = 1'b0;
    root_done   = 1'b1;
    root_result = 20'h77777;
    step();
    root_done = 1'b0;
    @(negedge clk);
    chk("wrong_unit_ignored", out_valid, 0);
    repeat (6) step();
    drive_done(MODE_DIV, 20'hA0021);
    @(negedge clk);
    chk("ord0_valid_early", out_valid, 0);
    step();
    clear_done();
    @(negedge clk);
    chk("ord0_valid", out_valid, 1);
    chk("ord0_data", out_data, 20'hA0021);
    chk("ord0_mode", out_mode, MODE_DIV);
    chk("ord0_err", out_err, 0);
    st = div_starts + root_starts;
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 20'hA0021);
      chk("stall_no_start", div_start || root_start, 0);
    end
    chk("stall_no_issue", div_starts + root_starts - st, 0);
    step();
    handshake(h);
    wait_start(MODE_ROOT, "ord1");
    chk("ord1_gap", cyc - h, 2);
    chk("ord1_d1", unit_data_1, 81);
    chk("ord1_d2", unit_data_2, 2);
    repeat (3) step();
    drive_done(MODE_ROOT, 20'h00009);
    step();
    clear_done();
    @(negedge clk);
    chk("ord1_data", out_data, 20'h00009);
    chk("ord1_mode", out_mode, MODE_ROOT);
    step();
    handshake(h);
    wait_start(MODE_DIV, "ord2");
    chk("ord2_gap", cyc - h, 2);
    chk("ord2_d1", unit_data_1, 50);
    step();
    drive_done(MODE_DIV, 20'h0000A);
    step();
    clear_done();
    @(negedge clk);
    chk("ord2_data", out_data, 20'h0000A);
    chk("ord2_mode", out_mode, MODE_DIV);
    step();
    handshake(h);
    @(negedge clk);
    chk("ord_busy_done", busy, 0);
    step();

    // Reset asserted while waiting with two ops queued.
    req_valid = 1'b1;
    req_mode = MODE_DIV; req_data_1 = 10'd7; req_data_2 = 3'd1; step();
    req_data_1 = 10'd8; step();
    req_data_1 = 10'd9; step();
    req_valid = 1'b0;
    step();
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    st = div_starts + root_starts;
    step();
    drive_done(MODE_DIV, 20'h12345);
    step();
    clear_done();
    repeat (8) step();
    @(negedge clk);
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_no_start", div_starts + root_starts - st, 0);
    chk("never_both_starts", both_starts, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
